phase_freq_avg: RTL and testbench

Frequency discriminator placed directly downstream of `atan2`. It takes the stream of wrapped phase words, differentiates successive valid samples modulo 2π to get instantaneous frequency, and block-averages 2^LOG2_AVG differences. Each completed block produces one averaged frequency word with a one-cycle valid strobe.

---
 rtl/phase_pkg.sv | 16 +
 rtl/phase_diff.sv | 31 +++
 rtl/phase_freq_avg.sv | 89 ++++++++
 tb/tb_phase_freq_avg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared phase-domain helpers: FSM state type and modular phase difference.
package phase_pkg;

  typedef enum logic {PRIME = 1'b0, ACCUM = 1'b1} phase_st_t;

  // Returns (a - b) mod 2^w as a signed value, sign-extended to 32 bits.
  // Callers size-cast the result down to their own word width.
  function automatic logic signed [31:0] phase_wrap_diff(input logic [31:0] a,
                                                         input logic [31:0] b,
                                                         input int unsigned w);
    logic [31:0] raw;
    raw = a - b;
    return $signed(raw << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/phase_diff.sv
// Holds the previous valid phase sample and forms the wrapped delta against it.
module phase_diff
  import phase_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        sink,
  input  logic                    sink_valid,
  output logic signed [WIDTH-1:0] d,
  output logic                    d_valid
);

  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (sink_valid) prev_d = sink;
  end

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= prev_d;
  end

  // Delta is combinational so a block's final sample lands on the same edge.
  assign d       = WIDTH'(phase_wrap_diff(32'(sink), 32'(prev_q), WIDTH));
  assign d_valid = sink_valid;

endmodule

// File: rtl/phase_freq_avg.sv
// Frequency discriminator: wrapped phase differences block-averaged over 2^LOG2_AVG.
module phase_freq_avg
  import phase_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOG2_AVG = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sink,
  input  logic             sink_valid,
  output logic [WIDTH-1:0] source,
  output logic             source_valid
);

  localparam int ACC_W = WIDTH + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  phase_st_t               st_q, st_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        source_q, source_d;
  logic                    source_valid_q, source_valid_d;

  logic signed [WIDTH-1:0] d;
  logic                    d_valid;
  logic signed [ACC_W-1:0] sum;
  logic                    last;

  phase_diff #(.WIDTH(WIDTH)) u_diff (
    .clk        (clk),
    .reset      (reset),
    .sink       (sink),
    .sink_valid (sink_valid),
    .d          (d),
    .d_valid    (d_valid)
  );

  assign sum  = acc_q + ACC_W'(d);
  // With LOG2_AVG = 0 the counter is pinned at 0, so every delta closes a block.
  assign last = (cnt_q == CNT_W'((1 << LOG2_AVG) - 1));

  always_comb begin
    st_d           = st_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    source_d       = source_q;
    source_valid_d = 1'b0;
    case (st_q)
      PRIME: begin
        if (d_valid) st_d = ACCUM;
      end
      ACCUM: begin
        if (d_valid) begin
          if (last) begin
            source_d       = WIDTH'(sum >>> LOG2_AVG);
            source_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: st_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q           <= PRIME;
      acc_q          <= '0;
      cnt_q          <= '0;
      source_q       <= '0;
      source_valid_q <= 1'b0;
    end else begin
      st_q           <= st_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      source_q       <= source_d;
      source_valid_q <= source_valid_d;
    end
  end

  assign source       = source_q;
  assign source_valid = source_valid_q;

endmodule

// File: tb/tb_phase_freq_avg.sv
// Directed bench for phase_freq_avg (WIDTH=16, LOG2_AVG=2) with an arithmetic reference model.
module tb_phase_freq_avg;

  localparam int W = 16;
  localparam int L = 2;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sink_valid = 1'b0;
  logic [W-1:0] sink = '0;
  logic [W-1:0] source;
  logic         source_valid;

  always #5 clk = ~clk;

  phase_freq_avg #(.WIDTH(W), .LOG2_AVG(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink         (sink),
    .sink_valid   (sink_valid),
    .source       (source),
    .source_valid (source_valid)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int n_valid = 0;

  bit m_primed = 1'b0;
  int m_prev = 0, m_sum = 0, m_n = 0, m_d = 0, m_s = 0;
  int exp_src = 0;
  bit exp_vld = 1'b0;

  int got_q[$];
  int got_idx[$];
  int got_cyc[$];
  int mod_q[$];

  function automatic int wrap16(input int x);
    int r;
    r = x;
    if (r > 32767) r -= 65536;
    else if (r < -32768) r += 65536;
    return r;
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q -= 1;
    return q;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference model: mean of wrapped deltas over each group of N, floored.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_primed <= 1'b0; m_prev <= 0; m_sum <= 0; m_n <= 0;
      exp_src <= 0; exp_vld <= 1'b0; n_valid <= 0;
    end else begin
      exp_vld <= 1'b0;
      if (sink_valid) begin
        n_valid <= n_valid + 1;
        m_prev  <= int'($signed(sink));
        if (!m_primed) m_primed <= 1'b1;
        else begin
          m_d = wrap16(int'($signed(sink)) - m_prev);
          m_s = m_sum + m_d;
          if (m_n == N - 1) begin
            exp_src <= floor_div(m_s, N);
            exp_vld <= 1'b1;
            m_sum   <= 0;
            m_n     <= 0;
          end else begin
            m_sum <= m_s;
            m_n   <= m_n + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("source_valid", int'(source_valid), int'(exp_vld));
    check("source", int'($signed(source)), exp_src);
    if (source_valid) begin
      got_q.push_back(int'($signed(source)));
      got_idx.push_back(n_valid);
      got_cyc.push_back(cyc);
    end
    if (exp_vld) mod_q.push_back(exp_src);
  end

  task automatic send(input int v, input int gap);
    sink = W'(v);
    sink_valid = 1'b1;
    @(posedge clk); #1;
    sink_valid = 1'b0;
    sink = W'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete(); got_idx.delete(); got_cyc.delete(); mod_q.delete();
  endtask

  task automatic check_single(input string name, input int want);
    check({name, "_count"}, got_q.size(), 1);
    check({name, "_model_count"}, mod_q.size(), 1);
    if (got_q.size() == 1) check({name, "_value"}, got_q[0], want);
    if (mod_q.size() == 1) check({name, "_model_value"}, mod_q[0], want);
  endtask

  int wv[5] = '{32750, 32760, -32766, -32756, -32746};
  int rp[5] = '{0, 1, 3, 5, 7};

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      sink = W'($urandom);
      sink_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    check("reset_source", int'(source), 0);
    check("reset_valid", int'(source_valid), 0);
    reset = 1'b0;
    sink_valid = 1'b0;
    idle(1);

    // Constant step, full rate.
    do_reset(); clear_q();
    for (int i = 0; i <= 12; i++) send(17 * i, 0);
    idle(2);
    check("ramp_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      check("ramp_value", got_q[i], 17);
      check("ramp_sample_idx", got_idx[i], 5 + 4 * i);
    end
    check("ramp_model_count", mod_q.size(), 3);
    if (mod_q.size() > 0) check("ramp_model_value", mod_q[0], 17);

    // Wrap-around ascending across +/-pi.
    do_reset(); clear_q();
    for (int i = 0; i < 5; i++) send(wv[i], 0);
    idle(2);
    check_single("wrap_up", 10);

    // Descending step -3 crossing -pi.
    do_reset(); clear_q();
    for (int i = 0; i < 5; i++) send(wrap16(-32760 - 3 * i), 0);
    idle(2);
    check_single("wrap_down", -3);

    // Floor rounding, positive and negative.
    do_reset(); clear_q();
    for (int i = 0; i < 5; i++) send(rp[i], 0);
    idle(2);
    check_single("round_pos", 1);
    do_reset(); clear_q();
    for (int i = 0; i < 5; i++) send(-rp[i], 0);
    idle(2);
    check_single("round_neg", -2);

    // Gapped valid: one sample every 3rd cycle.
    do_reset(); clear_q();
    for (int i = 0; i <= 8; i++) send(17 * i, 2);
    idle(2);
    check("gap_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("gap_value0", got_q[0], 17);
      check("gap_value1", got_q[1], 17);
      check("gap_spacing", got_cyc[1] - got_cyc[0], 12);
    end

    // Reset mid-block, then a ramp far from the pre-reset samples.
    do_reset(); clear_q();
    send(0, 0); send(17, 0); send(34, 0);
    do_reset(); clear_q();
    for (int i = 0; i < 4; i++) send(1000 + 5 * i, 0);
    idle(1);
    check("midrst_no_early", got_q.size(), 0);
    send(1020, 0);
    idle(2);
    check_single("midrst", 5);
    if (got_idx.size() == 1) check("midrst_sample_idx", got_idx[0], 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
